// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style built-in self-test initiator for a single-port
// synchronous RAM. A start pulse in IDLE runs three passes: ascending fill
// with E(a) = PATTERN ^ a, ascending read/compare with inverse write-back,
// then descending verify of the inverse. Every output comes straight from a
// register, so output next-values are derived from the FSM's next state.
module ram_bist_ctrl #(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam int CNT_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD1,
        S_CMP1,
        S_RD2,
        S_CMP2,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;

    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic                fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;

    logic                mismatch;

    // Background pattern for address a: PATTERN XOR zero-extended a.
    function automatic logic [DATA_W-1:0] expected_data(input logic [ADDR_W-1:0] addr);
        return PATTERN ^ DATA_W'(addr);
    endfunction

    // State and address counter register; synchronous reset returns to IDLE.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
        end
    end

    // Next-state and address sequencing for the three march passes.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    a_d     = '0;
                end
            end
            S_FILL: begin
                if (a_q == LAST_ADDR) begin
                    state_d = S_RD1;
                    a_d     = '0;
                end else begin
                    a_d = a_q + ADDR_W'(1);
                end
            end
            S_RD1: state_d = S_CMP1;
            S_CMP1: begin
                // The final address ends the pass; a_q never wraps.
                if (a_q == LAST_ADDR) begin
                    state_d = S_RD2;
                    a_d     = LAST_ADDR;
                end else begin
                    state_d = S_RD1;
                    a_d     = a_q + ADDR_W'(1);
                end
            end
            S_RD2: state_d = S_CMP2;
            S_CMP2: begin
                if (a_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RD2;
                    a_d     = a_q - ADDR_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Compare read data against the value the current pass expects.
    always_comb begin
        mismatch = 1'b0;
        if (state_q == S_CMP1) begin
            mismatch = (ram_dout != expected_data(a_q));
        end else if (state_q == S_CMP2) begin
            mismatch = (ram_dout != ~expected_data(a_q));
        end
    end

    // Output next-values: RAM port follows the upcoming state, results are
    // cleared on an accepted start and updated on each mismatch.
    always_comb begin
        ram_we_d     = 1'b0;
        ram_addr_d   = '0;
        ram_din_d    = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_addr_d  = fail_addr_q;

        unique case (state_d)
            S_FILL: begin
                ram_we_d   = 1'b1;
                ram_addr_d = a_d;
                ram_din_d  = expected_data(a_d);
                busy_d     = 1'b1;
            end
            S_CMP1: begin
                ram_we_d   = 1'b1;
                ram_addr_d = a_d;
                ram_din_d  = ~expected_data(a_d);
                busy_d     = 1'b1;
            end
            S_RD1, S_RD2, S_CMP2: begin
                ram_addr_d = a_d;
                busy_d     = 1'b1;
            end
            S_FIN:   done_d = 1'b1;
            default: ;
        endcase

        if (state_q == S_IDLE && start) begin
            err_count_d  = '0;
            fail_valid_d = 1'b0;
            fail_addr_d  = '0;
            pass_d       = 1'b0;
        end

        if (mismatch) begin
            if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            if (!fail_valid_q) begin
                fail_valid_d = 1'b1;
                fail_addr_d  = a_q;
            end
        end

        // Uses the updated count so the last compare of pass 3 is included.
        if (state_d == S_FIN) begin
            pass_d = (err_count_d == '0);
        end
    end

    // Output registers; reset drops the RAM write enable at the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
        end else begin
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_addr  = fail_addr_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: a 16x8 RAM model with selectable faults, a write
// scoreboard filled when each run is started, and a result scoreboard popped
// on the done pulse.
module tb_ram_bist_ctrl;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int DONE_CYC = 5 * DEPTH + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W+1:0] err_count;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;

    ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model. fault_mode: 0 = good, 1 = read bit 0 stuck at 0,
    // 2 = address bit 3 ignored.
    int                fault_mode;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] eff_addr;

    always_comb begin
        eff_addr = (fault_mode == 2) ? {1'b0, ram_addr[2:0]} : ram_addr;
    end

    always @(posedge clk) begin
        if (ram_we) mem[eff_addr] <= ram_din;
        ram_dout <= (fault_mode == 1) ? (mem[eff_addr] & 8'hFE) : mem[eff_addr];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int err;
        bit fv;
        int faddr;
        bit ok;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [DATA_W-1:0] exp_e(input int a);
        return 8'hA5 ^ 8'(a);
    endfunction

    // One full run: push expected writes and result, pulse start, then watch
    // cycle by cycle. xs* are extra start pulses (cycle numbers, -1 = none);
    // rst_cyc >= 0 aborts the run with rst asserted in that cycle.
    task automatic drive_run(input string name, input int mode, input int exp_err,
                             input bit exp_fv, input int exp_faddr,
                             input int xs1, input int xs2, input int xs3,
                             input int rst_cyc, input int exp_err_rst);
        res_t exp_r;
        res_t got_r;
        int   cyc;
        int   done_cnt;
        int   done_at;
        wr_t  w;
        fault_mode = mode;
        for (int a = 0; a < DEPTH; a++) wq.push_back('{addr: ADDR_W'(a), data: exp_e(a)});
        for (int a = 0; a < DEPTH; a++) wq.push_back('{addr: ADDR_W'(a), data: ~exp_e(a)});
        exp_r = '{err: exp_err, fv: exp_fv, faddr: exp_faddr, ok: (exp_err == 0)};
        rq.push_back(exp_r);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc      = 1;
        done_cnt = 0;
        done_at  = -1;
        while (cyc <= DONE_CYC + 8) begin
            if (cyc == 1) begin
                n_total++;
                if ({busy, pass, fail_valid, err_count, fail_addr} !== {1'b1, 1'b0, 1'b0, 6'd0, 4'd0})
                    $display("FAIL %s start_clear: busy=%0b pass=%0b fv=%0b err=%0d fa=%0d, required busy=1 others 0",
                             name, busy, pass, fail_valid, err_count, fail_addr);
                else n_pass++;
            end
            if (ram_we === 1'b1) begin
                n_total++;
                if (wq.size() == 0) begin
                    $display("FAIL %s extra_write: cycle %0d addr=%0h din=%0h, required no write",
                             name, cyc, ram_addr, ram_din);
                end else begin
                    w = wq.pop_front();
                    if ({ram_addr, ram_din} !== {w.addr, w.data})
                        $display("FAIL %s write: cycle %0d got addr=%0h din=%0h, required addr=%0h din=%0h",
                                 name, cyc, ram_addr, ram_din, w.addr, w.data);
                    else n_pass++;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = cyc;
                    n_total++;
                    if (rq.size() == 0) begin
                        $display("FAIL %s result: done with no expected result queued", name);
                    end else begin
                        got_r = rq.pop_front();
                        if ({int'(err_count), fail_valid, int'(fail_addr), pass, busy} !==
                            {got_r.err, got_r.fv, got_r.faddr, got_r.ok, 1'b0})
                            $display("FAIL %s result: err=%0d fv=%0b fa=%0d pass=%0b busy=%0b, required err=%0d fv=%0b fa=%0d pass=%0b busy=0",
                                     name, err_count, fail_valid, fail_addr, pass, busy,
                                     got_r.err, got_r.fv, got_r.faddr, got_r.ok);
                        else n_pass++;
                    end
                end
            end
            if (cyc == rst_cyc) begin
                n_total++;
                if ({busy, fail_valid, int'(err_count)} !== {1'b1, 1'b1, exp_err_rst})
                    $display("FAIL %s pre_reset: busy=%0b fv=%0b err=%0d, required busy=1 fv=1 err=%0d",
                             name, busy, fail_valid, err_count, exp_err_rst);
                else n_pass++;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                n_total++;
                if ({ram_we, busy, done, pass, fail_valid, err_count, fail_addr, ram_addr, ram_din} !== '0)
                    $display("FAIL %s post_reset: we=%0b busy=%0b done=%0b pass=%0b fv=%0b err=%0d fa=%0d addr=%0d din=%0h, required all 0",
                             name, ram_we, busy, done, pass, fail_valid, err_count, fail_addr, ram_addr, ram_din);
                else n_pass++;
                repeat (3) @(negedge clk);
                n_total++;
                if ({ram_we, busy} !== 2'b00)
                    $display("FAIL %s idle_after_reset: we=%0b busy=%0b, required 0 0", name, ram_we, busy);
                else n_pass++;
                wq.delete();
                rq.delete();
                return;
            end
            start = (cyc == xs1 || cyc == xs2 || cyc == xs3);
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end

        n_total++;
        if (done_cnt != 1 || done_at != DONE_CYC)
            $display("FAIL %s done_timing: %0d pulses first at cycle %0d, required 1 pulse at cycle %0d",
                     name, done_cnt, done_at, DONE_CYC);
        else n_pass++;
        n_total++;
        if (wq.size() != 0) begin
            $display("FAIL %s missing_writes: %0d writes outstanding, required 0", name, wq.size());
            wq.delete();
        end else n_pass++;
        n_total++;
        if ({int'(err_count), fail_valid, int'(fail_addr), pass, busy, ram_we} !==
            {exp_r.err, exp_r.fv, exp_r.faddr, exp_r.ok, 1'b0, 1'b0})
            $display("FAIL %s idle_hold: err=%0d fv=%0b fa=%0d pass=%0b busy=%0b we=%0b, required err=%0d fv=%0b fa=%0d pass=%0b busy=0 we=0",
                     name, err_count, fail_valid, fail_addr, pass, busy, ram_we,
                     exp_r.err, exp_r.fv, exp_r.faddr, exp_r.ok);
        else n_pass++;
        rq.delete();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({ram_we, busy, done, pass, fail_valid, err_count, fail_addr, ram_addr, ram_din} !== '0)
            $display("FAIL reset_values: we=%0b busy=%0b done=%0b pass=%0b fv=%0b err=%0d fa=%0d addr=%0d din=%0h, required all 0",
                     ram_we, busy, done, pass, fail_valid, err_count, fail_addr, ram_addr, ram_din);
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({ram_we, busy, done} !== 3'b000)
            $display("FAIL reset_idle: we=%0b busy=%0b done=%0b, required 0 0 0", ram_we, busy, done);
        else n_pass++;
    endtask

    task automatic test_fault_free();
        int bad;
        drive_run("fault_free", 0, 0, 1'b0, 0, -1, -1, -1, -1, 0);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ~exp_e(a)) bad++;
        n_total++;
        if (bad != 0) $display("FAIL ram_final_contents: %0d locations differ from ~(A5^a), required 0", bad);
        else n_pass++;
    endtask

    task automatic test_stuck_bit0();
        drive_run("stuck_bit0", 1, 16, 1'b1, 0, -1, -1, -1, -1, 0);
    endtask

    task automatic test_addr_alias();
        drive_run("addr_alias", 2, 24, 1'b1, 0, -1, -1, -1, -1, 0);
    endtask

    // Follows a failing run: the new start must clear the old results, and
    // starts while busy or coincident with done must be ignored.
    task automatic test_back_to_back();
        drive_run("back_to_back", 0, 0, 1'b0, 0, 10, 40, DONE_CYC, -1, 0);
    endtask

    task automatic test_mid_reset();
        drive_run("mid_reset", 1, 0, 1'b0, 0, -1, -1, -1, 30, 3);
        drive_run("after_reset", 0, 0, 1'b0, 0, -1, -1, -1, -1, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        fault_mode = 0;
        test_reset();
        test_fault_free();
        test_stuck_bit0();
        test_back_to_back();
        test_addr_alias();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator for the team's single-port synchronous RAM (write-enable, address, write data, read data).
- On a start pulse it takes ownership of the RAM port and runs a three-pass march: fill, read/compare with inverse write, then descending verify.
- It reports busy, done, pass/fail, error count and first failing address. It sits beside the RAM, muxed onto its port during test.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width; must be >= ADDR_W.
- PATTERN, 8'hA5, DATA_W-bit base test pattern.

Ports:
- clk  input  1  rising-edge clock shared with the RAM.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data; valid the cycle after a read address is presented with ram_we=0.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the test completes.
- pass  output  1  valid from done until the next start; 1 when err_count==0.
- err_count  output  ADDR_W+2  number of mismatches; saturates at all-ones.
- fail_valid  output  1  set on the first mismatch of a run.
- fail_addr  output  ADDR_W  address of the first mismatch; holds 0 while fail_valid=0.

Behaviour:
- All outputs are driven directly from registers. Reset values: ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_addr=0. Reset places the FSM in IDLE.
- Expected data: E(a) = PATTERN XOR zero-extended a.
- States and transitions:
  - IDLE: ram_we=0. When start=1, clear err_count, fail_valid, fail_addr and pass; set busy; go to FILL with a=0.
  - FILL: one cycle per address. ram_we=1, ram_addr=a, ram_din=E(a). Ascending 0..DEPTH-1, then go to RD1 with a=0.
  - RD1: ram_we=0, ram_addr=a. Next state is CMP1.
  - CMP1: compare ram_dout with E(a). In the same cycle drive ram_we=1, ram_addr=a, ram_din=~E(a). Increment a; when a==DEPTH-1, go to RD2 with a=DEPTH-1; otherwise go to RD1.
  - RD2: ram_we=0, ram_addr=a. Next state is CMP2.
  - CMP2: compare ram_dout with ~E(a), with no write. Decrement a; after a==0, go to FIN.
  - FIN: pulse done for one cycle, clear busy, set pass=(err_count==0), return to IDLE.
- Timing: start is accepted at edge 0. FILL occupies cycles 1..DEPTH, pass 2 takes 2*DEPTH cycles, pass 3 takes 2*DEPTH cycles. done is high in cycle 5*DEPTH+1, which is cycle 81 for the defaults.
- Mismatch handling: a mismatch in CMP1 or CMP2 increments err_count, saturating at all-ones. If fail_valid=0, it also sets fail_valid=1 and captures fail_addr=a. Later mismatches do not change fail_addr.
- start while busy is ignored. start in the same cycle as the done pulse is also ignored.
- A synchronous rst at any point, including mid-pass, forces the reset values at the next edge. ram_we drops immediately. No partial result is retained.
- Address counter wrap: a never wraps within a pass. Termination is decided by the compare on the final address, not by overflow.
- pass, err_count, fail_valid and fail_addr hold their values in IDLE until the next accepted start.

Test Plan:
- Fault-free 16x8 RAM model, start pulse -> 16 FILL writes of A5^a, done at cycle 81, pass=1, err_count=0, fail_valid=0. After the run, RAM location a holds ~(A5^a).
- RAM model with read-data bit 0 stuck at 0 -> pass 2 fails on even addresses (8 errors), pass 3 fails on odd addresses (8 errors). Result: err_count=16, fail_valid=1, fail_addr=0, pass=0.
- RAM model ignoring address bit 3 (8..15 alias 0..7) -> 8 errors in pass 2 at a=0..7, 8 in pass 2 at a=8..15, 8 in pass 3 at a=7..0. Result: err_count=24, fail_addr=0, pass=0.
- Assert rst for one cycle during pass 2 (cycle 30) -> next edge: ram_we=0, busy=0, err_count=0, FSM in IDLE. A new start then completes cleanly with done at start+81.
- Pulse start again at cycles 10 and 40 during a run -> both ignored, and done still occurs exactly once at cycle 81. A start pulse in IDLE after done begins a new run and clears the previous results.
